// File: rtl/tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tx_ctrl
// Description : Framed UART (8N1) transmitter. It sends one of four frame
//               types, each made of a control byte and an optional payload:
//                 CONNECT : 0x00
//                 ACK     : 0xFF
//                 SCORE   : 0x01, score[15:8], score[7:0]
//                 MAP     : 0x02, dot[127:120] ... dot[7:0]  (17 bytes)
//               Requests are level-sampled while idle and arbitrated with
//               the priority ACK > CONNECT > SCORE > MAP. The payload is
//               captured on the launch cycle, so later changes to the
//               inputs do not affect the frame being sent. Bytes are sent
//               back to back with no idle gap between them.
//
// Parameters  : CLK_PER_BIT  clock cycles per UART bit (2 or more)
//
// Ports       : clk          system clock, rising edge
//               i_rst_n      asynchronous active-low reset
//               i_req_conn   request CONNECT frame
//               i_req_ack    request ACK frame
//               i_req_score  request SCORE frame
//               i_req_map    request MAP frame
//               i_score      SCORE payload (16 bits)
//               i_dot        MAP payload (128 bits)
//               o_tx         serial line, idle high
//               o_busy       frame in progress
//               o_done       one-cycle pulse on the first idle cycle after
//                            a frame
//               o_byte_idx   index of the byte on the line (0 = control)
//
// Options     : TX_CTRL_PENDING_EN  when defined, requests that arrive
//               while a frame is in flight are remembered per type and
//               served once the transmitter is idle again. When undefined,
//               such requests are dropped and no pending storage exists.
//
// Revision    : 1.0  initial release
// ============================================================================
module tx_ctrl #(
    parameter int CLK_PER_BIT = 434
) (
    input  logic         clk,
    input  logic         i_rst_n,
    input  logic         i_req_conn,
    input  logic         i_req_ack,
    input  logic         i_req_score,
    input  logic         i_req_map,
    input  logic [15:0]  i_score,
    input  logic [127:0] i_dot,
    output logic         o_tx,
    output logic         o_busy,
    output logic         o_done,
    output logic [4:0]   o_byte_idx
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam int                 c_CNT_W    = $clog2(CLK_PER_BIT);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(CLK_PER_BIT - 1);

    // Request / grant bit positions
    localparam int c_ACK   = 0;
    localparam int c_CONN  = 1;
    localparam int c_SCORE = 2;
    localparam int c_MAP   = 3;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_clk_cnt;
    logic [2:0]         r_bit_cnt;
    logic [4:0]         r_byte_idx;
    logic [4:0]         r_last_idx;
    logic [7:0]         r_shift;
    logic [127:0]       r_snap;
    logic               r_tx;
    logic               r_busy;
    logic               r_done;

    // ------------------------------------------------------------------------
    // Request arbitration
    // ------------------------------------------------------------------------
    logic [3:0] w_req_live;
    logic [3:0] w_req;
    logic [3:0] w_grant;
    logic       w_launch;

    assign w_req_live = {i_req_map, i_req_score, i_req_conn, i_req_ack};

`ifdef TX_CTRL_PENDING_EN
    logic [3:0] r_pend;

    assign w_req = w_req_live | r_pend;

    // A request seen during a frame is remembered; it is cleared only when
    // a frame of that same type actually launches.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pend <= 4'b0000;
        end else if (w_launch) begin
            r_pend <= r_pend & ~w_grant;
        end else if (r_busy) begin
            r_pend <= r_pend | w_req_live;
        end
    end
`else
    assign w_req = w_req_live;
`endif

    always_comb begin
        w_grant = 4'b0000;
        if (w_req[c_ACK]) begin
            w_grant[c_ACK] = 1'b1;
        end else if (w_req[c_CONN]) begin
            w_grant[c_CONN] = 1'b1;
        end else if (w_req[c_SCORE]) begin
            w_grant[c_SCORE] = 1'b1;
        end else if (w_req[c_MAP]) begin
            w_grant[c_MAP] = 1'b1;
        end
    end

    assign w_launch = (r_state == ST_IDLE) && (|w_req);

    // ------------------------------------------------------------------------
    // Frame description for the granted type. The payload is left-aligned
    // in the snapshot so every following byte is taken from the top.
    // ------------------------------------------------------------------------
    logic [7:0]   w_ctrl_byte;
    logic [4:0]   w_last_idx;
    logic [127:0] w_snap;

    always_comb begin
        w_ctrl_byte = 8'h00;
        w_last_idx  = 5'd0;
        w_snap      = '0;
        if (w_grant[c_ACK]) begin
            w_ctrl_byte = 8'hFF;
        end else if (w_grant[c_SCORE]) begin
            w_ctrl_byte = 8'h01;
            w_last_idx  = 5'd2;
            w_snap      = {i_score, 112'd0};
        end else if (w_grant[c_MAP]) begin
            w_ctrl_byte = 8'h02;
            w_last_idx  = 5'd16;
            w_snap      = i_dot;
        end
    end

    // ------------------------------------------------------------------------
    // Transmit state machine. o_tx is registered, so the start bit appears
    // on the cycle after the launch.
    // ------------------------------------------------------------------------
    logic w_bit_end;

    assign w_bit_end = (r_clk_cnt == c_CNT_LAST);

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_clk_cnt  <= '0;
            r_bit_cnt  <= 3'd0;
            r_byte_idx <= 5'd0;
            r_last_idx <= 5'd0;
            r_shift    <= 8'h00;
            r_snap     <= '0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_clk_cnt  <= '0;
                    r_bit_cnt  <= 3'd0;
                    r_byte_idx <= 5'd0;
                    r_tx       <= 1'b1;
                    if (w_launch) begin
                        r_state    <= ST_START;
                        r_shift    <= w_ctrl_byte;
                        r_last_idx <= w_last_idx;
                        r_snap     <= w_snap;
                        r_tx       <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end

                ST_START: begin
                    if (w_bit_end) begin
                        r_clk_cnt <= '0;
                        r_bit_cnt <= 3'd0;
                        r_tx      <= r_shift[0];
                        r_state   <= ST_DATA;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end

                ST_DATA: begin
                    if (w_bit_end) begin
                        r_clk_cnt <= '0;
                        if (r_bit_cnt == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= ST_STOP;
                        end else begin
                            // LSB first: the next bit is the one above the
                            // current line value before the shift.
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_tx      <= r_shift[1];
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end

                ST_STOP: begin
                    if (w_bit_end) begin
                        r_clk_cnt <= '0;
                        if (r_byte_idx == r_last_idx) begin
                            r_state    <= ST_IDLE;
                            r_busy     <= 1'b0;
                            r_done     <= 1'b1;
                            r_byte_idx <= 5'd0;
                            r_tx       <= 1'b1;
                        end else begin
                            // Next byte starts immediately, no idle gap.
                            r_byte_idx <= r_byte_idx + 5'd1;
                            r_shift    <= r_snap[127:120];
                            r_snap     <= {r_snap[119:0], 8'h00};
                            r_tx       <= 1'b0;
                            r_state    <= ST_START;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

    assign o_tx       = r_tx;
    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_byte_idx = r_byte_idx;

endmodule
`default_nettype wire

// File: tb/tb_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_tx_ctrl
// Description : Self-checking bench for tx_ctrl with CLK_PER_BIT = 4.
//               Expected bytes are queued when a frame is requested; a line
//               monitor decodes the serial output and compares each byte
//               and its byte index against the queue.
// Revision    : 1.0  initial release
// ============================================================================
module tb_tx_ctrl;

    localparam int CPB = 4;

    logic         clk;
    logic         rst_n;
    logic         req_conn;
    logic         req_ack;
    logic         req_score;
    logic         req_map;
    logic [15:0]  score;
    logic [127:0] dot;
    logic         tx;
    logic         busy;
    logic         done;
    logic [4:0]   byte_idx;

    tx_ctrl #(.CLK_PER_BIT(CPB)) dut (
        .clk         (clk),
        .i_rst_n     (rst_n),
        .i_req_conn  (req_conn),
        .i_req_ack   (req_ack),
        .i_req_score (req_score),
        .i_req_map   (req_map),
        .i_score     (score),
        .i_dot       (dot),
        .o_tx        (tx),
        .o_busy      (busy),
        .o_done      (done),
        .o_byte_idx  (byte_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] data;
        logic [4:0] idx;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input logic [7:0] ctrl, input int n, input logic [127:0] pay);
        exp_t e;
        e.data = ctrl;
        e.idx  = 5'd0;
        sb.push_back(e);
        for (int i = 1; i < n; i++) begin
            e.data = pay[127 - 8*(i-1) -: 8];
            e.idx  = 5'(i);
            sb.push_back(e);
        end
    endtask

    // Called on the negedge of the first busy cycle (cycle 1).
    task automatic wait_done(output int busy_cnt, output int done_cyc, output int one_cyc);
        busy_cnt = 0;
        done_cyc = -1;
        one_cyc  = -1;
        for (int c = 1; c <= 3000; c++) begin
            if (done === 1'b1) begin
                done_cyc = c;
                break;
            end
            if (busy === 1'b1) busy_cnt++;
            if (one_cyc < 0 && tx === 1'b1) one_cyc = c;
            @(negedge clk);
        end
    endtask

    task automatic idle_watch(input int n, output int busy_seen, output int done_seen, output int low_seen);
        busy_seen = 0;
        done_seen = 0;
        low_seen  = 0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if (busy !== 1'b0) busy_seen++;
            if (done !== 1'b0) done_seen++;
            if (tx !== 1'b1) low_seen++;
        end
    endtask

    // ------------------------------------------------------------------------
    // Line monitor: mid-bit sampling, cnt 0 = first start-bit cycle.
    // ------------------------------------------------------------------------
    logic       mon_act  = 1'b0;
    int         mon_cnt  = 0;
    logic       mon_have = 1'b0;
    logic [7:0] mon_byte = 8'h00;
    exp_t       mon_exp;

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                mon_act = 1'b0;
                mon_cnt = 0;
                sb.delete();
            end else if (!mon_act) begin
                if (tx === 1'b0) begin
                    mon_act  = 1'b1;
                    mon_cnt  = 0;
                    mon_have = 1'b0;
                end
            end else begin
                mon_cnt++;
                if (mon_cnt == 2) begin
                    check("start_bit", tx, 0);
                    check("byte_expected", (sb.size() != 0), 1);
                    if (sb.size() != 0) begin
                        mon_exp  = sb.pop_front();
                        mon_have = 1'b1;
                        check("byte_idx", byte_idx, mon_exp.idx);
                    end
                end else if (mon_cnt >= 6 && mon_cnt <= 34 && ((mon_cnt - 2) % CPB) == 0) begin
                    mon_byte[(mon_cnt - 6) / CPB] = tx;
                end else if (mon_cnt == 38) begin
                    check("stop_bit", tx, 1);
                    if (mon_have) check("byte_data", mon_byte, mon_exp.data);
                end else if (mon_cnt == 39) begin
                    mon_act = 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------------
    localparam logic [127:0] MAP_PAY = 128'h00112233445566778899AABBCCDDEEFF;

    initial begin
        int b, d, o;
        int bs, ds, ls;

        rst_n     = 1'b0;
        req_conn  = 1'b0;
        req_ack   = 1'b0;
        req_score = 1'b0;
        req_map   = 1'b0;
        score     = 16'h0000;
        dot       = '0;

        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_idx", byte_idx, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // SCORE frame
        score = 16'h1234;
        push_frame(8'h01, 3, {16'h1234, 112'd0});
        req_score = 1'b1;
        @(negedge clk);
        req_score = 1'b0;
        wait_done(b, d, o);
        check("score_busy", b, 120);
        check("score_done_cycle", d, 121);
        @(negedge clk);
        check("score_done_width", done, 0);
        check("idle_tx", tx, 1);
        check("idle_idx", byte_idx, 0);

        // MAP frame
        dot = MAP_PAY;
        push_frame(8'h02, 17, MAP_PAY);
        req_map = 1'b1;
        @(negedge clk);
        req_map = 1'b0;
        wait_done(b, d, o);
        check("map_busy", b, 680);
        check("map_done_cycle", d, 681);
        repeat (2) @(negedge clk);

        // CONNECT bit timing
        push_frame(8'h00, 1, '0);
        req_conn = 1'b1;
        @(negedge clk);
        req_conn = 1'b0;
        wait_done(b, d, o);
        check("conn_first_high", o, 37);
        check("conn_done_cycle", d, 41);
        check("conn_busy", b, 40);
        repeat (2) @(negedge clk);

        // ACK and MAP together, MAP held through o_done
        push_frame(8'hFF, 1, '0);
        push_frame(8'h02, 17, MAP_PAY);
        req_ack = 1'b1;
        req_map = 1'b1;
        @(negedge clk);
        req_ack = 1'b0;
        wait_done(b, d, o);
        check("ack_first_busy", b, 40);
        check("ack_first_done", d, 41);
        @(negedge clk);
        req_map = 1'b0;
        wait_done(b, d, o);
        check("map_after_ack_busy", b, 680);
        check("map_after_ack_done", d, 681);
        repeat (2) @(negedge clk);

        // ACK, then a one-cycle MAP request while busy
        push_frame(8'hFF, 1, '0);
        req_ack = 1'b1;
        @(negedge clk);
        req_ack = 1'b0;
        repeat (10) @(negedge clk);
        req_map = 1'b1;
`ifdef TX_CTRL_PENDING_EN
        push_frame(8'h02, 17, MAP_PAY);
`endif
        @(negedge clk);
        req_map = 1'b0;
        wait_done(b, d, o);
        check("busy_req_ack_busy", b, 29);
        check("busy_req_ack_done", d, 30);
`ifdef TX_CTRL_PENDING_EN
        @(negedge clk);
        wait_done(b, d, o);
        check("pending_map_busy", b, 680);
        check("pending_map_done", d, 681);
`else
        idle_watch(60, bs, ds, ls);
        check("dropped_map_busy", bs, 0);
        check("dropped_map_line", ls, 0);
`endif
        repeat (2) @(negedge clk);

        // Snapshot: payload change during the second byte
        score = 16'h1234;
        push_frame(8'h01, 3, {16'h1234, 112'd0});
        req_score = 1'b1;
        @(negedge clk);
        req_score = 1'b0;
        repeat (44) @(negedge clk);
        score = 16'hABCD;
        wait_done(b, d, o);
        check("snap_busy", b, 76);
        check("snap_done", d, 77);
        repeat (2) @(negedge clk);

        // Reset during a MAP data bit
        push_frame(8'h02, 17, MAP_PAY);
        req_map = 1'b1;
        @(negedge clk);
        req_map = 1'b0;
        repeat (60) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_tx", tx, 1);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_idx", byte_idx, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle_watch(100, bs, ds, ls);
        check("post_rst_busy", bs, 0);
        check("post_rst_done", ds, 0);
        check("post_rst_line", ls, 0);

        check("scoreboard_empty", sb.size(), 0);
        check("monitor_idle", mon_act, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
